// File: rtl/flash_loader.sv
// Streams words from a valid/ready source into flash as erase/program(/verify) commands.
// Optional read-back verify is compiled in with `define FLASH_LOADER_VERIFY_EN.
module flash_loader #(
    parameter int BLOCK_BITS  = 16,
    parameter int RDY_TIMEOUT = 1000000,
    parameter int GUARD       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [21:0] base_addr,
    input  logic [15:0] count,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        mem_run,
    output logic [1:0]  mem_com,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_endop,
    input  logic        flash_rdy,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  state_dbg
);

    localparam int GW = $clog2(GUARD + 2);
    localparam int RW = $clog2(RDY_TIMEOUT + 2);
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_ERASE = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ERASE, S_PROG, S_VERIFY,
        S_CMD_WAIT, S_GUARD, S_RDY_WAIT, S_NEXT, S_FINISH
    } state_t;

    state_t          state, next_state;
    logic [21:0]     cur_addr;
    logic [15:0]     remaining;
    logic [15:0]     word_reg;
    logic            first_word;
    logic [1:0]      cmd_reg;
    logic [GW-1:0]   guard_cnt;
    logic [RW-1:0]   rdy_cnt;
    logic            rdy_meta, rdy_sync;
    logic            error_r;
    logic            set_error;

    // Word input: a word transfers on any clk edge where in_valid && in_ready;
    // in_valid/in_data must hold until that edge, in_ready is high only in FETCH.

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        set_error  = 1'b0;
        in_ready   = 1'b0;
        mem_run    = 1'b0;
        mem_com    = cmd_reg;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) next_state = (count == 16'd0) ? S_FINISH : S_FETCH;
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = (first_word || cur_addr[BLOCK_BITS-1:0] == '0) ? S_ERASE : S_PROG;
            end
            S_ERASE: begin
                mem_run    = 1'b1;
                mem_com    = CMD_ERASE;
                next_state = S_CMD_WAIT;
            end
            S_PROG: begin
                mem_run    = 1'b1;
                mem_com    = CMD_WRITE;
                next_state = S_CMD_WAIT;
            end
            S_VERIFY: begin
`ifdef FLASH_LOADER_VERIFY_EN
                mem_run    = 1'b1;
                mem_com    = CMD_READ;
                next_state = S_CMD_WAIT;
`else
                next_state = S_NEXT;
`endif
            end
            S_CMD_WAIT: begin
                if (mem_endop) begin
                    if (cmd_reg == CMD_READ) begin
`ifdef FLASH_LOADER_VERIFY_EN
                        if (mem_rdata != word_reg) begin
                            set_error  = 1'b1;
                            next_state = S_FINISH;
                        end else begin
                            next_state = S_NEXT;
                        end
`else
                        next_state = S_NEXT;
`endif
                    end else if (GUARD == 0) begin
                        next_state = S_RDY_WAIT;
                    end else begin
                        next_state = S_GUARD;
                    end
                end
            end
            S_GUARD: begin
                if (guard_cnt == GW'(GUARD - 1)) next_state = S_RDY_WAIT;
            end
            S_RDY_WAIT: begin
                if (rdy_sync) begin
                    // An erase is always followed by programming the word it was issued for.
                    if (cmd_reg == CMD_ERASE) next_state = S_PROG;
`ifdef FLASH_LOADER_VERIFY_EN
                    else                      next_state = S_VERIFY;
`else
                    else                      next_state = S_NEXT;
`endif
                end else if (rdy_cnt == RW'(RDY_TIMEOUT - 1)) begin
                    set_error  = 1'b1;
                    next_state = S_FINISH;
                end
            end
            S_NEXT: begin
                next_state = (remaining != 16'd1) ? S_FETCH : S_FINISH;
            end
            S_FINISH: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr   <= '0;
            remaining  <= '0;
            word_reg   <= '0;
            first_word <= 1'b0;
            cmd_reg    <= '0;
            guard_cnt  <= '0;
            rdy_cnt    <= '0;
            rdy_meta   <= 1'b0;
            rdy_sync   <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rdy_meta <= flash_rdy;
            rdy_sync <= rdy_meta;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        remaining  <= count;
                        error_r    <= 1'b0;
                        first_word <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        word_reg   <= in_data;
                        first_word <= 1'b0;
                    end
                end
                S_ERASE:    cmd_reg <= CMD_ERASE;
                S_PROG:     cmd_reg <= CMD_WRITE;
                S_VERIFY:   cmd_reg <= CMD_READ;
                S_CMD_WAIT: begin
                    guard_cnt <= '0;
                    rdy_cnt   <= '0;
                end
                S_GUARD:    guard_cnt <= guard_cnt + GW'(1);
                S_RDY_WAIT: rdy_cnt   <= rdy_cnt + RW'(1);
                S_NEXT: begin
                    cur_addr  <= cur_addr + 22'd1;
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
            if (set_error) error_r <= 1'b1;
        end
    end

`ifndef FLASH_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign mem_addr  = cur_addr;
    assign mem_wdata = word_reg;
    assign busy      = (state != S_IDLE);
    assign error     = error_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_flash_loader.sv
// Randomised bench for flash_loader: a behavioural flash/word-source model and an
// expected command list derived from base address, count and words.
`timescale 1ns/1ps
module tb_flash_loader;
    localparam int TO = 50;
    localparam int GD = 4;
`ifdef FLASH_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [21:0] base_addr = '0;
    logic [15:0] count = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, mem_run;
    logic [1:0]  mem_com;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_endop = 1'b0;
    logic        flash_rdy = 1'b0;
    logic        busy, done, error;
    logic [3:0]  state_dbg;

    flash_loader #(.BLOCK_BITS(16), .RDY_TIMEOUT(TO), .GUARD(GD)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_run(mem_run), .mem_com(mem_com), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_endop(mem_endop), .flash_rdy(flash_rdy),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    int n_checks = 0, n_pass = 0;
    int viol_cnt = 0, cyc = 0, endop_cyc = 0, pend_cnt = 0, rdy_busy = 0;
    bit hold_low = 1'b0, corrupt = 1'b0, prev_run = 1'b0, fire_pend = 1'b0;
    logic [39:0] pend_cmd = '0;
    logic [39:0] exp_q[$], obs_q[$];
    logic [15:0] src_q[$], words_q[$];
    logic [15:0] fmem [logic [21:0]];

    // clock / reset
    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    // flash controller model: records commands, random latency, busy after erase/program
    always @(negedge clk) begin
        if (reset) begin
            pend_cnt = 0; mem_endop = 1'b0; rdy_busy = 0; flash_rdy = 1'b0; prev_run = 1'b0;
        end else begin
            mem_endop = 1'b0;
            if (pend_cnt > 0) begin
                if ({mem_com, mem_addr, mem_wdata} !== pend_cmd) viol_cnt++;
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_endop = 1'b1;
                    endop_cyc = cyc;
                    if (pend_cmd[39:38] == 2'd2) fmem[pend_cmd[37:16]] = pend_cmd[15:0];
                    if (pend_cmd[39:38] == 2'd1)
                        mem_rdata = (fmem.exists(pend_cmd[37:16]) ? fmem[pend_cmd[37:16]] : 16'hFFFF)
                                    ^ {15'd0, corrupt};
                end
            end
            if (mem_run) begin
                if (prev_run || pend_cnt != 0) viol_cnt++;
                pend_cmd = {mem_com, mem_addr, mem_wdata};
                obs_q.push_back(pend_cmd);
                pend_cnt = $urandom_range(1, 4);
                rdy_busy = pend_cnt + $urandom_range(0, 8);
            end
            prev_run = mem_run;
            if (rdy_busy > 0) rdy_busy--;
            flash_rdy = !hold_low && (rdy_busy == 0);
        end
    end

    // word source driver with random gaps
    always @(negedge clk) begin
        if (reset) begin
            in_valid = 1'b0; fire_pend = 1'b0;
        end else begin
            if (fire_pend && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_data = src_q[0];
            end else begin
                in_valid = 1'b0; in_data = 16'($urandom);
            end
            fire_pend = in_valid && in_ready;
        end
    end

    // reference model: command list implied by base, count and the word list
    task automatic build_exp(input logic [21:0] b, input int c);
        logic [21:0] a;
        exp_q.delete();
        for (int i = 0; i < c; i++) begin
            a = b + 22'(i);
            if (i == 0 || a[15:0] == 16'h0) exp_q.push_back({2'd3, a, words_q[i]});
            exp_q.push_back({2'd2, a, words_q[i]});
            if (VERIFY) exp_q.push_back({2'd1, a, words_q[i]});
        end
    endtask

    task automatic rand_words(input int c);
        words_q.delete();
        for (int i = 0; i < c; i++) words_q.push_back(16'($urandom));
    endtask

    task automatic drive_session(input logic [21:0] b, input logic [15:0] c, input int spur,
                                 output int wcyc, output bit got);
        obs_q.delete(); src_q = words_q; got = 1'b0; wcyc = 0;
        @(negedge clk); base_addr = b; count = c; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 150 * int'(c) + 100 && !got; i++) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                if (i == spur) begin base_addr = ~b; count = 16'd7; start = 1'b1; end
                else start = 1'b0;
                @(negedge clk); wcyc++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_run, mem_com, mem_addr, mem_wdata, in_ready, busy, done, error} !== '0)
            $display("FAIL reset_outputs got %h want 0", {mem_run, mem_com, mem_addr, mem_wdata, in_ready, busy, done, error});
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, in_ready, mem_run} !== 3'b000) $display("FAIL idle_after_reset got %b want 000", {busy, in_ready, mem_run});
        else n_pass++;
    endtask

    task automatic test_basic;
        int w; bit got;
        words_q = '{16'h1234, 16'h5678};
        build_exp(22'h10000, 2);
        drive_session(22'h10000, 16'd2, -1, w, got);
        n_checks++; if (!got) $display("FAIL basic done got 0 want 1"); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic cmd_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic cmd%0d got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (error !== 1'b0) $display("FAIL basic error got %b want 0", error); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, busy} !== 2'b00) $display("FAIL basic done_pulse got %b want 00", {done, busy}); else n_pass++;
    endtask

    task automatic test_block_cross;
        int w; bit got;
        rand_words(2);
        build_exp(22'h1FFFF, 2);
        drive_session(22'h1FFFF, 16'd2, -1, w, got);
        n_checks++; if (!got) $display("FAIL cross done got 0 want 1"); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL cross cmd_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL cross cmd%0d got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_count_zero;
        int w; bit got;
        words_q.delete();
        drive_session(22'($urandom), 16'd0, -1, w, got);
        n_checks++; if (!got || w != 0) $display("FAIL zero done_delay got %0d (seen %b) want 0", w, got); else n_pass++;
        n_checks++; if (obs_q.size() != 0) $display("FAIL zero mem_run_count got %0d want 0", obs_q.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, busy, error} !== 3'b000) $display("FAIL zero after got %b want 000", {done, busy, error}); else n_pass++;
    endtask

    task automatic test_timeout;
        int w; bit got; int lat;
        hold_low = 1'b1;
        repeat (4) @(negedge clk);
        rand_words(2);
        drive_session(22'h20005, 16'd2, -1, w, got);
        lat = cyc - endop_cyc;
        n_checks++; if (!got) $display("FAIL timeout done got 0 want 1"); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL timeout error got %b want 1", error); else n_pass++;
        n_checks++; if (lat != GD + TO + 1) $display("FAIL timeout latency got %0d want %0d", lat, GD + TO + 1); else n_pass++;
        n_checks++; if (obs_q.size() != 1) $display("FAIL timeout cmd_count got %0d want 1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== {2'd3, 22'h20005, words_q[0]}) $display("FAIL timeout cmd0 got %h want %h", obs_q[0], {2'd3, 22'h20005, words_q[0]}); else n_pass++;
        end
        n_checks++; if (src_q.size() != 1) $display("FAIL timeout words_left got %0d want 1", src_q.size()); else n_pass++;
        hold_low = 1'b0;
        src_q.delete();
        repeat (3) @(negedge clk);
    endtask

`ifdef FLASH_LOADER_VERIFY_EN
    task automatic test_verify_mismatch;
        int w; bit got;
        corrupt = 1'b1;
        words_q = '{16'h1234, 16'h5678};
        build_exp(22'h10000, 1);
        drive_session(22'h10000, 16'd2, -1, w, got);
        n_checks++; if (!got) $display("FAIL verify done got 0 want 1"); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL verify error got %b want 1", error); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL verify cmd_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL verify cmd%0d got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (src_q.size() != 1) $display("FAIL verify words_left got %0d want 1", src_q.size()); else n_pass++;
        corrupt = 1'b0;
        src_q.delete();
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_random;
        int w, c; bit got; logic [21:0] b;
        for (int k = 0; k < 8; k++) begin
            c = $urandom_range(1, 5);
            case (k % 3)
                0: b = 22'($urandom);
                1: b = {6'($urandom), 16'hFFFF - 16'($urandom_range(0, 3))};
                default: b = 22'h3FFFFF - 22'($urandom_range(0, 2));
            endcase
            rand_words(c);
            build_exp(b, c);
            drive_session(b, 16'(c), -1, w, got);
            n_checks++; if (!got) $display("FAIL random%0d done got 0 want 1", k); else n_pass++;
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL random%0d cmd_count got %0d want %0d", k, obs_q.size(), exp_q.size()); else n_pass++;
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL random%0d cmd%0d got %h want %h", k, i, obs_q[i], exp_q[i]); else n_pass++;
            end
            n_checks++; if ({error, 1'(src_q.size() != 0)} !== 2'b00) $display("FAIL random%0d error_left got %b want 00", k, {error, 1'(src_q.size() != 0)}); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        int w; bit got; logic [21:0] b;
        for (int k = 0; k < 2; k++) begin
            b = {6'($urandom), 16'h4000 + 16'($urandom_range(0, 255))};
            rand_words(3 - k);
            build_exp(b, 3 - k);
            drive_session(b, 16'(3 - k), (k == 0) ? 8 : -1, w, got);
            n_checks++; if (!got) $display("FAIL b2b%0d done got 0 want 1", k); else n_pass++;
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b%0d cmd_count got %0d want %0d", k, obs_q.size(), exp_q.size()); else n_pass++;
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b%0d cmd%0d got %h want %h", k, i, obs_q[i], exp_q[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_cmd;
        int w, n; bit got, found;
        rand_words(3);
        obs_q.delete(); src_q = words_q; found = 1'b0;
        @(negedge clk); base_addr = 22'h00123; count = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (pend_cnt > 0 && pend_cmd[39:38] == 2'd2) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!found) $display("FAIL rst_mid prog_seen got 0 want 1"); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({mem_run, mem_com, mem_addr, mem_wdata, in_ready, busy, done, error} !== '0)
            $display("FAIL rst_mid outputs got %h want 0", {mem_run, mem_com, mem_addr, mem_wdata, in_ready, busy, done, error});
        else n_pass++;
        n = obs_q.size();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        src_q.delete();
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() != n || busy !== 1'b0) $display("FAIL rst_mid quiet got %0d/%b want %0d/0", obs_q.size(), busy, n); else n_pass++;
        rand_words(2);
        build_exp(22'h00200, 2);
        drive_session(22'h00200, 16'd2, -1, w, got);
        n_checks++; if (!got || error !== 1'b0) $display("FAIL rst_mid restart got %b/%b want 1/0", got, error); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rst_mid cmd_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rst_mid cmd%0d got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_block_cross;
        test_count_zero;
        test_timeout;
`ifdef FLASH_LOADER_VERIFY_EN
        test_verify_mismatch;
`endif
        test_random;
        test_back_to_back;
        test_reset_mid_cmd;
        n_checks++; if (viol_cnt != 0) $display("FAIL protocol violations got %0d want 0", viol_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(40 * 80000);
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
